// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse sequencer: FSM states, timing units
// and the ROM code-entry format.
package morse_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MARK,
      S_EGAP,
      S_CGAP,
      S_SPACE
   } state_t;

   typedef enum logic [1:0] {
      KIND_NONE,
      KIND_CHAR,
      KIND_SPACE
   } kind_t;

   // pattern is left-aligned: element 0 sits in bit 5, 1 = dah
   typedef struct packed {
      logic [2:0] len;
      logic [5:0] pattern;
      kind_t      kind;
   } code_t;

   localparam logic [2:0] DIT   = 3'd1;
   localparam logic [2:0] DAH   = 3'd3;
   localparam logic [2:0] EGAP  = 3'd1;
   localparam logic [2:0] CGAP  = 3'd3;
   localparam logic [2:0] SPACE = 3'd4;

   localparam code_t CODE_NONE  = '{len: 3'd0, pattern: 6'd0, kind: KIND_NONE};
   localparam code_t CODE_SPACE = '{len: 3'd0, pattern: 6'd0, kind: KIND_SPACE};

   // Table entries are written right-aligned for readability, then left-aligned here
   function automatic code_t makeCode(input logic [2:0] len, input logic [5:0] elems);
      code_t c;
      c.len     = len;
      c.pattern = elems << (3'd6 - len);
      c.kind    = KIND_CHAR;
      return c;
   endfunction

endpackage

// File: rtl/morse_rom.sv
// ASCII to Morse code-entry lookup with a registered output; lowercase letters
// are folded to uppercase before the lookup.
module morse_rom
   import morse_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic [7:0] i_data,
   output code_t      o_code
);

   logic [7:0] w_upper;
   code_t      w_code;

   always_comb begin
      w_upper = i_data;
      if (i_data >= 8'h61 && i_data <= 8'h7A) begin
         w_upper = i_data - 8'h20;
      end
   end

   always_comb begin
      w_code = CODE_NONE;
      case (w_upper)
         "A": w_code = makeCode(3'd2, 6'b000001);
         "B": w_code = makeCode(3'd4, 6'b001000);
         "C": w_code = makeCode(3'd4, 6'b001010);
         "D": w_code = makeCode(3'd3, 6'b000100);
         "E": w_code = makeCode(3'd1, 6'b000000);
         "F": w_code = makeCode(3'd4, 6'b000010);
         "G": w_code = makeCode(3'd3, 6'b000110);
         "H": w_code = makeCode(3'd4, 6'b000000);
         "I": w_code = makeCode(3'd2, 6'b000000);
         "J": w_code = makeCode(3'd4, 6'b000111);
         "K": w_code = makeCode(3'd3, 6'b000101);
         "L": w_code = makeCode(3'd4, 6'b000100);
         "M": w_code = makeCode(3'd2, 6'b000011);
         "N": w_code = makeCode(3'd2, 6'b000010);
         "O": w_code = makeCode(3'd3, 6'b000111);
         "P": w_code = makeCode(3'd4, 6'b000110);
         "Q": w_code = makeCode(3'd4, 6'b001101);
         "R": w_code = makeCode(3'd3, 6'b000010);
         "S": w_code = makeCode(3'd3, 6'b000000);
         "T": w_code = makeCode(3'd1, 6'b000001);
         "U": w_code = makeCode(3'd3, 6'b000001);
         "V": w_code = makeCode(3'd4, 6'b000001);
         "W": w_code = makeCode(3'd3, 6'b000011);
         "X": w_code = makeCode(3'd4, 6'b001001);
         "Y": w_code = makeCode(3'd4, 6'b001011);
         "Z": w_code = makeCode(3'd4, 6'b001100);
         "0": w_code = makeCode(3'd5, 6'b011111);
         "1": w_code = makeCode(3'd5, 6'b001111);
         "2": w_code = makeCode(3'd5, 6'b000111);
         "3": w_code = makeCode(3'd5, 6'b000011);
         "4": w_code = makeCode(3'd5, 6'b000001);
         "5": w_code = makeCode(3'd5, 6'b000000);
         "6": w_code = makeCode(3'd5, 6'b010000);
         "7": w_code = makeCode(3'd5, 6'b011000);
         "8": w_code = makeCode(3'd5, 6'b011100);
         "9": w_code = makeCode(3'd5, 6'b011110);
         ".": w_code = makeCode(3'd6, 6'b010101);
         ",": w_code = makeCode(3'd6, 6'b110011);
         "?": w_code = makeCode(3'd6, 6'b001100);
         "/": w_code = makeCode(3'd5, 6'b010010);
         "=": w_code = makeCode(3'd5, 6'b010001);
         " ": w_code = CODE_SPACE;
         default: w_code = CODE_NONE;
      endcase
   end

   // Only loads on an accepted byte, so the entry holds for the whole character
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_code <= CODE_NONE;
      end else if (i_en) begin
         o_code <= w_code;
      end
   end

endmodule

// File: rtl/morse_sequencer.sv
// Morse character sequencer: ASCII in over valid/ready, key line out.
// Define MORSE_SEQ_FARNSWORTH_EN to add i_gapTicks for stretched character/word gaps.
module morse_sequencer
   import morse_pkg::*;
#(
   parameter int DOT_WIDTH = 24
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [7:0]           i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DOT_WIDTH-1:0] i_dotTicks,
`ifdef MORSE_SEQ_FARNSWORTH_EN
   input  logic [DOT_WIDTH-1:0] i_gapTicks,
`endif
   output logic                 o_key,
   output logic                 o_busy
);

   localparam logic [DOT_WIDTH-1:0] TICK_ONE = {{(DOT_WIDTH-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_nextState;
   logic                 r_ready;
   logic [DOT_WIDTH-1:0] r_dotTicks;
   logic [DOT_WIDTH-1:0] w_period;
   logic [DOT_WIDTH-1:0] r_tick;
   logic [2:0]           r_unit;
   logic [2:0]           w_units;
   logic [2:0]           r_remain;
   logic [5:0]           r_shift;
   logic                 w_accept;
   logic                 w_timed;
   logic                 w_unitDone;
   logic                 w_stateDone;
   code_t                w_code;

   assign w_accept = i_valid & r_ready;
   assign o_ready  = r_ready;

   morse_rom u_rom (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (w_accept),
      .i_data  (i_data),
      .o_code  (w_code)
   );

`ifdef MORSE_SEQ_FARNSWORTH_EN
   logic [DOT_WIDTH-1:0] r_gapTicks;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_gapTicks <= TICK_ONE;
      end else if (w_accept) begin
         r_gapTicks <= (i_gapTicks == '0) ? TICK_ONE : i_gapTicks;
      end
   end

   assign w_period = (r_state == S_CGAP || r_state == S_SPACE) ? r_gapTicks : r_dotTicks;
`else
   assign w_period = r_dotTicks;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_dotTicks <= TICK_ONE;
      end else if (w_accept) begin
         r_dotTicks <= (i_dotTicks == '0) ? TICK_ONE : i_dotTicks;
      end
   end

   always_comb begin
      w_units = DIT;
      case (r_state)
         S_MARK:  w_units = r_shift[5] ? DAH : DIT;
         S_EGAP:  w_units = EGAP;
         S_CGAP:  w_units = CGAP;
         S_SPACE: w_units = SPACE;
         default: w_units = DIT;
      endcase
   end

   assign w_timed     = (r_state == S_MARK) || (r_state == S_EGAP) ||
                        (r_state == S_CGAP) || (r_state == S_SPACE);
   assign w_unitDone  = (r_tick == w_period - TICK_ONE);
   assign w_stateDone = w_timed && w_unitDone && (r_unit == w_units - 3'd1);

   // Both counters restart on every state change, so each state lasts units x period
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tick <= '0;
         r_unit <= '0;
      end else if (!w_timed || w_nextState != r_state) begin
         r_tick <= '0;
         r_unit <= '0;
      end else if (w_unitDone) begin
         r_tick <= '0;
         r_unit <= r_unit + 3'd1;
      end else begin
         r_tick <= r_tick + TICK_ONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shift  <= '0;
         r_remain <= '0;
      end else if (r_state == S_LOOKUP) begin
         r_shift  <= w_code.pattern;
         r_remain <= w_code.len;
      end else if (r_state == S_MARK && w_stateDone) begin
         r_shift  <= {r_shift[4:0], 1'b0};
         r_remain <= r_remain - 3'd1;
      end
   end

   // Ready is registered from the next state so it is low throughout reset
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_ready <= (w_nextState == S_IDLE);
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_nextState = S_LOOKUP;
         S_LOOKUP: begin
            case (w_code.kind)
               KIND_CHAR:  w_nextState = S_MARK;
               KIND_SPACE: w_nextState = S_SPACE;
               default:    w_nextState = S_IDLE;
            endcase
         end
         S_MARK:   if (w_stateDone) w_nextState = (r_remain > 3'd1) ? S_EGAP : S_CGAP;
         S_EGAP:   if (w_stateDone) w_nextState = S_MARK;
         S_CGAP:   if (w_stateDone) w_nextState = S_IDLE;
         S_SPACE:  if (w_stateDone) w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      o_key  = (r_state == S_MARK);
      o_busy = (r_state != S_IDLE);
   end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: a dot/dash string model predicts every
// mark and every return to ready; a negedge monitor compares what the DUT does.
module tb_morse_sequencer;

   logic        i_clk;
   logic        i_reset;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        o_ready;
   logic [23:0] i_dotTicks;
   logic [23:0] i_gapTicks;
   logic        o_key;
   logic        o_busy;

   typedef struct {
      int rise;
      int len;
   } markExp_t;

   markExp_t   keyQ[$];
   int         readyQ[$];
   string      morseTab[logic [7:0]];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   logic       prevKey = 1'b0;
   logic       prevReady = 1'b0;
   int         riseCyc = 0;

   morse_sequencer dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_dotTicks (i_dotTicks),
`ifdef MORSE_SEQ_FARNSWORTH_EN
      .i_gapTicks (i_gapTicks),
`endif
      .o_key      (o_key),
      .o_busy     (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   always @(posedge i_clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Model: a byte accepted at cycle t0 keys its first mark from t0+1, then
   // plays its dot/dash string, then a 3-unit character gap before ready.
   task automatic modelPush(input logic [7:0] b, input int dot, input int gap, input int t0);
      logic [7:0] c;
      int         d;
      int         g;
      int         t;
      string      s;
      markExp_t   e;
      c = b;
      if (c >= "a" && c <= "z") c = c - 8'd32;
      d = (dot == 0) ? 1 : dot;
`ifdef MORSE_SEQ_FARNSWORTH_EN
      g = (gap == 0) ? 1 : gap;
`else
      g = d;
      if (gap < 0) g = d;
`endif
      t = t0 + 1;
      if (c == " ") begin
         readyQ.push_back(t + 4 * g);
      end else if (morseTab.exists(c)) begin
         s = morseTab[c];
         for (int i = 0; i < s.len(); i++) begin
            e.rise = t;
            e.len  = (s[i] == "-") ? 3 * d : d;
            keyQ.push_back(e);
            t += e.len;
            if (i < s.len() - 1) t += d;
         end
         readyQ.push_back(t + 3 * g);
      end else begin
         readyQ.push_back(t);
      end
   endtask

   // Called at posedge+2; returns at posedge+2 just after the transfer edge
   task automatic applyStimulus(input logic [7:0] b, input int dot, input int gap);
      logic rdy;
      bit   done;
      done       = 1'b0;
      i_data     = b;
      i_valid    = 1'b1;
      i_dotTicks = 24'(dot);
      i_gapTicks = 24'(gap);
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge i_clk);
         rdy = o_ready;
         @(posedge i_clk);
         #2;
         if (rdy) begin
            done = 1'b1;
            modelPush(b, dot, gap, cyc);
         end
      end
      i_valid    = 1'b0;
      i_data     = 8'($urandom);
      i_dotTicks = 24'($urandom_range(0, 15));
      i_gapTicks = 24'($urandom_range(0, 15));
      if (!done) checkOutput("handshake timeout", 0, 1);
   endtask

   always @(negedge i_clk) begin
      if (i_reset) begin
         prevKey   = 1'b0;
         prevReady = 1'b0;
      end else begin
         if (o_key && !prevKey) begin
            riseCyc = cyc;
            checkOutput("busy during mark", int'(o_busy), 1);
         end
         if (!o_key && prevKey) begin
            if (keyQ.size() == 0) begin
               checkOutput("unexpected mark", 1, 0);
            end else begin
               markExp_t e;
               e = keyQ.pop_front();
               checkOutput("mark start", riseCyc, e.rise);
               checkOutput("mark length", cyc - riseCyc, e.len);
            end
         end
         if (o_ready && !prevReady) begin
            if (readyQ.size() == 0) begin
               checkOutput("unexpected ready", 1, 0);
            end else begin
               checkOutput("ready return", cyc, readyQ.pop_front());
            end
            checkOutput("busy at ready", int'(o_busy), 0);
         end
         prevKey   = o_key;
         prevReady = o_ready;
      end
   end

   function automatic logic [7:0] randomChar();
      string punct;
      punct = ".,?/=";
      case ($urandom_range(0, 9))
         3:       return 8'("a" + $urandom_range(0, 25));
         4:       return 8'("0" + $urandom_range(0, 9));
         5:       return punct[$urandom_range(0, 4)];
         6:       return " ";
         7:       return 8'($urandom);
         default: return 8'("A" + $urandom_range(0, 25));
      endcase
   endfunction

   initial begin
      morseTab["A"] = ".-";    morseTab["B"] = "-...";  morseTab["C"] = "-.-.";
      morseTab["D"] = "-..";   morseTab["E"] = ".";     morseTab["F"] = "..-.";
      morseTab["G"] = "--.";   morseTab["H"] = "....";  morseTab["I"] = "..";
      morseTab["J"] = ".---";  morseTab["K"] = "-.-";   morseTab["L"] = ".-..";
      morseTab["M"] = "--";    morseTab["N"] = "-.";    morseTab["O"] = "---";
      morseTab["P"] = ".--.";  morseTab["Q"] = "--.-";  morseTab["R"] = ".-.";
      morseTab["S"] = "...";   morseTab["T"] = "-";     morseTab["U"] = "..-";
      morseTab["V"] = "...-";  morseTab["W"] = ".--";   morseTab["X"] = "-..-";
      morseTab["Y"] = "-.--";  morseTab["Z"] = "--..";
      morseTab["0"] = "-----"; morseTab["1"] = ".----"; morseTab["2"] = "..---";
      morseTab["3"] = "...--"; morseTab["4"] = "....-"; morseTab["5"] = ".....";
      morseTab["6"] = "-...."; morseTab["7"] = "--..."; morseTab["8"] = "---..";
      morseTab["9"] = "----."; morseTab["."] = ".-.-.-"; morseTab[","] = "--..--";
      morseTab["?"] = "..--.."; morseTab["/"] = "-..-."; morseTab["="] = "-...-";

      i_reset    = 1'b1;
      i_data     = 8'h00;
      i_valid    = 1'b0;
      i_dotTicks = 24'd4;
      i_gapTicks = 24'd4;
      repeat (3) @(posedge i_clk);
      #2;
      checkOutput("reset key", int'(o_key), 0);
      checkOutput("reset ready", int'(o_ready), 0);
      checkOutput("reset busy", int'(o_busy), 0);
      i_reset = 1'b0;
      readyQ.push_back(cyc + 1);
      @(posedge i_clk);
      #2;

      $display("[TB] directed characters");
      applyStimulus("E", 4, 4);
      applyStimulus("A", 4, 4);
      applyStimulus("E", 2, 2);
      applyStimulus(" ", 2, 2);
      applyStimulus("E", 2, 2);
      applyStimulus("#", 3, 3);
      applyStimulus("T", 0, 0);
      applyStimulus("q", 1, 1);
      applyStimulus("E", 2, 5);
      applyStimulus("E", 2, 5);

      $display("[TB] reset during a mark");
      applyStimulus("0", 10, 10);
      repeat (6) @(posedge i_clk);
      #3;
      checkOutput("key before reset", int'(o_key), 1);
      i_reset = 1'b1;
      #1;
      checkOutput("async key clear", int'(o_key), 0);
      checkOutput("async busy clear", int'(o_busy), 0);
      checkOutput("async ready clear", int'(o_ready), 0);
      keyQ.delete();
      readyQ.delete();
      repeat (2) @(posedge i_clk);
      #2;
      i_reset = 1'b0;
      readyQ.push_back(cyc + 1);
      applyStimulus("E", 3, 3);

      $display("[TB] random characters");
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) @(posedge i_clk);
            #2;
         end
         applyStimulus(randomChar(), $urandom_range(0, 3), $urandom_range(0, 6));
      end

      for (int k = 0; k < 5000 && (keyQ.size() != 0 || readyQ.size() != 0); k++) begin
         @(posedge i_clk);
      end
      repeat (2) @(posedge i_clk);
      checkOutput("marks outstanding", keyQ.size(), 0);
      checkOutput("ready returns outstanding", readyQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
